stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready consumer between NUM_REQ byte-stream producers, such as instances of the team's incrementing data producer.
- Grants one requester at a time, for a burst of up to MAX_BURST beats.
- Forwards the granted requester's data through a single registered output stage.
- Sits between the producer bank and the shared sink.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width per requester
MAX_BURST, 4, max beats accepted per grant before forced rotation (1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester valid
req_ready  output  NUM_REQ  per-requester ready (combinational)
req_data  input  NUM_REQ*DATA_W  requester i at bits [i*DATA_W +: DATA_W]
valid_out  output  1  downstream valid (registered)
ready_in  input  1  downstream ready
data_out  output  DATA_W  downstream data (registered)
grant_id  output  clog2(NUM_REQ)  index of current/last granted requester (registered)
busy  output  1  high while in state GRANT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: valid_out=0, data_out=0, grant_id=0, busy=0, state=IDLE, rr_ptr=0, burst_cnt=0. Reset asserted mid-burst aborts immediately, and any data held in the output register is dropped.
- Transfer definitions:
  - Upstream transfer on requester i: req_valid[i] && req_ready[i] in the same cycle.
  - Downstream transfer: valid_out && ready_in.
- Output register: out_free = !valid_out || ready_in.
  - On an upstream transfer, data_out <= req_data[grant_id] and valid_out <= 1.
  - Else, on a downstream transfer, valid_out <= 0.
  - Otherwise valid_out and data_out hold, so data is stable while stalled.
- req_ready[i] = busy && (grant_id==i) && out_free. All other req_ready bits are 0.
- FSM states: IDLE, GRANT.
  - IDLE, with any req_valid set: pick the first set bit scanning rr_ptr, rr_ptr+1, ..., modulo NUM_REQ. Register grant_id, clear burst_cnt, go to GRANT.
  - IDLE, with no req_valid set: stay in IDLE; grant_id holds.
  - GRANT, upstream transfer with burst_cnt==MAX_BURST-1: go to IDLE and set rr_ptr <= grant_id+1 (mod NUM_REQ).
  - GRANT, other upstream transfer: burst_cnt++.
  - GRANT, req_valid[grant_id]==0: release with no transfer that cycle; go to IDLE, rr_ptr <= grant_id+1.
  - GRANT, req_valid[grant_id]==1 but out_free==0 (stall): hold state and burst_cnt. A stall never counts toward the burst.
- Latency:
  - Request seen in IDLE at cycle t gives busy and grant_id at t+1.
  - With a free output, req_ready is high at t+1 and valid_out rises at t+2.
  - One arbitration bubble cycle follows every release.
- Fairness: a requester that holds valid is served within (NUM_REQ-1) bursts of the others.
- Simultaneous events: a downstream transfer and an upstream transfer in the same cycle reload data_out, and valid_out stays 1.
- Width rules:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - burst_cnt is 8 bits and never exceeds MAX_BURST-1.
- The arbiter never reorders or duplicates beats. Data is forwarded unmodified.

Optional Feature:
- Macro: ARB_BEAT_CNT_EN.
- Defined: adds output port beat_total (16 bits, registered).
  - Increments on every downstream transfer and saturates at 0xFFFF.
  - Reset value is 0.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then req_valid=4'b0000 for 10 cycles -> valid_out=0, busy=0, grant_id=0, req_ready=0.
2. Only req 2 valid, data 0x10,0x11,..., ready_in=1 -> grant_id=2 one cycle later. Exactly 4 beats 0x10..0x13 are accepted, then busy drops for 1 cycle and req 2 is re-granted. data_out sequence contains no gaps or duplicates.
3. All 4 requesters valid continuously, ready_in=1 -> grant order 0,1,2,3,0,... with 4 beats each. valid_out shows 1 idle cycle between bursts.
4. Req 1 granted, ready_in=0 for 5 cycles mid-burst -> data_out and valid_out hold, req_ready=0, burst_cnt unchanged. After ready_in=1 the remaining beats complete and the burst total is 4.
5. Req 3 granted, drops req_valid after 2 beats -> release with rr_ptr=0. The next grant goes to the lowest valid index starting at 0.
6. rst=1 mid-burst with valid_out=1 -> the next cycle shows valid_out=0 and state IDLE. With ARB_BEAT_CNT_EN, beat_total=0 after reset, and 0xFFFF stays 0xFFFF on further transfers.

Source files
------------

// File: rtl/stream_rr_arbiter_if.sv
// rtl/stream_rr_arbiter_if.sv - handshake bundle between the producer bank, the arbiter and the shared sink
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      valid_out;
    logic                      ready_in;
    logic [DATA_W-1:0]         data_out;
    logic [GW-1:0]             grant_id;
    logic                      busy;

    modport master (
        output req_valid, req_data, ready_in,
        input  req_ready, valid_out, data_out, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, ready_in,
        output req_ready, valid_out, data_out, grant_id, busy
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin burst arbiter with one registered output stage
// Optional registered beat_total counter enabled by ARB_BEAT_CNT_EN.
module stream_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_rr_arbiter_if.slave   bus
`ifdef ARB_BEAT_CNT_EN
    ,
    output logic [15:0]          beat_total
`endif
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [GW-1:0]     rr_ptr;
    logic [7:0]        burst_cnt;
    logic [GW-1:0]     pick_id;
    logic [GW-1:0]     next_ptr;
    logic              any_valid;
    logic              cur_valid;
    logic              out_free;
    logic              up_xfer;
    logic [DATA_W-1:0] cur_data;

    always_comb begin
        out_free  = !bus.valid_out || bus.ready_in;
        cur_valid = bus.req_valid[bus.grant_id];
        cur_data  = bus.req_data[int'(bus.grant_id)*DATA_W +: DATA_W];
        up_xfer   = bus.busy && cur_valid && out_free;
        any_valid = |bus.req_valid;
        next_ptr  = (bus.grant_id == GW'(NUM_REQ-1)) ? '0 : bus.grant_id + 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = bus.busy && (int'(bus.grant_id) == i) && out_free;
        end
    end

    // Scan from the far end back toward rr_ptr so the nearest valid requester wins.
    always_comb begin
        pick_id = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                pick_id = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            burst_cnt     <= '0;
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
            bus.grant_id  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            if (up_xfer) begin
                bus.data_out  <= cur_data;
                bus.valid_out <= 1'b1;
            end else if (bus.valid_out && bus.ready_in) begin
                bus.valid_out <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        bus.grant_id <= pick_id;
                        burst_cnt    <= '0;
                        state        <= GRANT;
                        bus.busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    // A stalled output neither advances the burst nor releases the grant.
                    if (!cur_valid) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        rr_ptr   <= next_ptr;
                    end else if (out_free) begin
                        if (burst_cnt == 8'(MAX_BURST-1)) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            rr_ptr   <= next_ptr;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_BEAT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_total <= '0;
        end else if (bus.valid_out && bus.ready_in && (beat_total != 16'hFFFF)) begin
            beat_total <= beat_total + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - randomized and directed bench for stream_rr_arbiter with a behavioural model
module tb_stream_rr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
`ifdef ARB_BEAT_CNT_EN
    logic [15:0] beat_total;
`endif

    stream_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_BEAT_CNT_EN
        ,
        .beat_total(beat_total)
`endif
    );

    // Incrementing producers: each advances only when its beat is taken.
    logic [DATA_W-1:0] pcnt [NUM_REQ];
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = pcnt[i];
    end

    int checks = 0;
    int errors = 0;
    bit armed = 0;

    // Model state, in plain integers.
    int          m_busy, m_gid, m_ptr, m_cnt, m_vout;
    logic [7:0]  m_dout;
    int          m_bt;
    int          cur_beats;
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] olog [$];
    int          glog [$];
    int          blog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    function automatic int oget(input int k);
        return (k < olog.size()) ? int'(olog[k]) : -1;
    endfunction

    task automatic release_grant();
        m_busy = 0;
        m_ptr  = (m_gid + 1) % NUM_REQ;
        blog.push_back(cur_beats);
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] xfer;
        logic [NUM_REQ-1:0] m_rdy;
        int m_free, m_up;
        @(negedge clk);
        m_free = (!m_vout || bus.ready_in) ? 1 : 0;
        for (int i = 0; i < NUM_REQ; i++) m_rdy[i] = (m_busy != 0) && (m_gid == i) && (m_free != 0);
        xfer = rst ? '0 : (bus.req_valid & bus.req_ready);
        if (armed) begin
            chk("req_ready", 32'(bus.req_ready), 32'(m_rdy));
            chk("valid_out", 32'(bus.valid_out), 32'(m_vout));
            chk("data_out",  32'(bus.data_out),  32'(m_dout));
            chk("grant_id",  32'(bus.grant_id),  32'(m_gid));
            chk("busy",      32'(bus.busy),      32'(m_busy));
`ifdef ARB_BEAT_CNT_EN
            chk("beat_total", 32'(beat_total), 32'(m_bt));
`endif
            if (!rst && bus.valid_out && bus.ready_in) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    chk("sb_order", 32'(bus.data_out), 32'(sb.pop_front()));
                end
                olog.push_back(bus.data_out);
            end
            for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) sb.push_back(pcnt[i]);
        end

        m_up = ((m_busy != 0) && bus.req_valid[m_gid] && (m_free != 0)) ? 1 : 0;
        if (rst) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_vout = 0; m_dout = '0;
            m_bt = 0; cur_beats = 0;
            sb.delete();
        end else begin
            if (m_vout != 0 && bus.ready_in && m_bt != 65535) m_bt++;
            if (m_up != 0) begin
                m_dout = pcnt[m_gid];
                m_vout = 1;
                cur_beats++;
            end else if (m_vout != 0 && bus.ready_in) begin
                m_vout = 0;
            end
            if (m_busy == 0) begin
                if (|bus.req_valid) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (bus.req_valid[(m_ptr + k) % NUM_REQ]) begin
                            m_gid = (m_ptr + k) % NUM_REQ;
                            break;
                        end
                    end
                    m_busy = 1;
                    m_cnt = 0;
                    cur_beats = 0;
                    glog.push_back(m_gid);
                end
            end else if (!bus.req_valid[m_gid]) begin
                release_grant();
            end else if (m_up != 0) begin
                if (m_cnt == MAX_BURST-1) release_grant();
                else m_cnt++;
            end
        end
        if (rst) armed = 1;

        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) pcnt[i] = pcnt[i] + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        glog.delete();
        blog.delete();
        olog.delete();
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) pcnt[i] = '0;
        bus.req_valid = '0;
        bus.ready_in  = 1'b1;

        // Idle after reset
        do_reset();
        for (int n = 0; n < 10; n++) tick();
        chk("idle_valid_out", 32'(bus.valid_out), 32'(0));
        chk("idle_busy",      32'(bus.busy),      32'(0));
        chk("idle_grant_id",  32'(bus.grant_id),  32'(0));
        chk("idle_req_ready", 32'(bus.req_ready), 32'(0));

        // Single requester: bursts of four with one bubble
        pcnt[2] = 8'h10;
        bus.req_valid = 4'b0100;
        tick();
        chk("p2_grant_id",  32'(bus.grant_id),  32'(2));
        chk("p2_busy",      32'(bus.busy),      32'(1));
        chk("p2_req_ready", 32'(bus.req_ready), 32'(4'b0100));
        chk("p2_vout_lat",  32'(bus.valid_out), 32'(0));
        tick();
        chk("p2_vout_rise", 32'(bus.valid_out), 32'(1));
        chk("p2_first",     32'(bus.data_out),  32'(8'h10));
        for (int n = 0; n < 10; n++) tick();
        chk("p2_burst0", 32'(qget(blog, 0)), 32'(4));
        chk("p2_burst1", 32'(qget(blog, 1)), 32'(4));
        chk("p2_regrant", 32'(qget(glog, 1)), 32'(2));
        for (int k = 0; k < 8; k++) chk("p2_seq", 32'(oget(k)), 32'(8'h10 + k));
        bus.req_valid = '0;
        for (int n = 0; n < 4; n++) tick();

        // All requesters: grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) pcnt[i] = 8'(i * 16);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 22; n++) tick();
        for (int k = 0; k < 5; k++) chk("p3_order", 32'(qget(glog, k)), 32'(k % NUM_REQ));
        for (int k = 0; k < 4; k++) chk("p3_burst", 32'(qget(blog, k)), 32'(4));

        // Downstream stall mid-burst
        do_reset();
        pcnt[1] = 8'h40;
        bus.req_valid = 4'b0010;
        for (int n = 0; n < 3; n++) tick();
        bus.ready_in = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("p4_hold_data",  32'(bus.data_out),  32'(8'h41));
            chk("p4_hold_valid", 32'(bus.valid_out), 32'(1));
            chk("p4_ready_low",  32'(bus.req_ready), 32'(0));
        end
        bus.ready_in = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        chk("p4_burst", 32'(qget(blog, 0)), 32'(4));

        // Early release: rr_ptr wraps to 0
        do_reset();
        pcnt[3] = 8'h80;
        bus.req_valid = 4'b1000;
        for (int n = 0; n < 3; n++) tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.req_valid = 4'b1010;
        tick();
        chk("p5_burst",  32'(qget(blog, 0)), 32'(2));
        chk("p5_next",   32'(qget(glog, 1)), 32'(1));
        chk("p5_grant",  32'(bus.grant_id),  32'(1));
        bus.req_valid = '0;
        for (int n = 0; n < 4; n++) tick();

        // Reset mid-burst with data held
        do_reset();
        pcnt[0] = 8'h55;
        bus.req_valid = 4'b0001;
        bus.ready_in = 1'b0;
        tick();
        tick();
        chk("p6_pre_valid", 32'(bus.valid_out), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("p6_valid", 32'(bus.valid_out), 32'(0));
        chk("p6_busy",  32'(bus.busy),      32'(0));
        chk("p6_data",  32'(bus.data_out),  32'(0));
`ifdef ARB_BEAT_CNT_EN
        chk("p6_beat_total", 32'(beat_total), 32'(0));
`endif
        bus.ready_in = 1'b1;

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) bus.req_valid = 4'($urandom_range(0, 15));
            bus.ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
